// File: rtl/spi_reg_ctrl.sv
// Sequences decoded SPI frames {CMD, ADDR, DATA} into local-bus write/read cycles
// and builds the response frame {STATUS, ADDR, DATA} for the next SPI transaction.
module spi_reg_ctrl #(
  parameter  int ADDR_WIDTH  = 12,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_LIMIT  = 'h100,
  parameter  int TIMEOUT     = 255,
  localparam int FRAME_WIDTH = 2 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                   iClk,
  input  logic                   iRstn,
  input  logic [FRAME_WIDTH-1:0] ivRX_FRAME,
  input  logic                   iRX_VALID,
  input  logic                   iTX_HOLD,
  output logic [FRAME_WIDTH-1:0] ovTX_FRAME,
  output logic                   oBUS_REQ,
  output logic                   oBUS_WR,
  output logic [ADDR_WIDTH-1:0]  ovBUS_ADDR,
  output logic [DATA_WIDTH-1:0]  ovBUS_WDATA,
  input  logic                   iBUS_ACK,
  input  logic [DATA_WIDTH-1:0]  ivBUS_RDATA,
  output logic                   oDONE
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_BUS, S_RESP} state_e;
  typedef enum logic [1:0] {CMD_NOP, CMD_WRITE, CMD_READ, CMD_STATUS} cmd_e;
  typedef enum logic [1:0] {ST_OK, ST_TIMEOUT, ST_BAD_ADDR, ST_OVERRUN} status_e;

  localparam int                    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIM = (ADDR_WIDTH + 1)'(ADDR_LIMIT);

  state_e                 state_q,        state_d;
  cmd_e                   cmd_q,          cmd_d;
  status_e                status_q,       status_d;
  logic [ADDR_WIDTH-1:0]  addr_q,         addr_d;
  logic [DATA_WIDTH-1:0]  data_q,         data_d;
  logic [CNT_W-1:0]       wait_cnt_q,     wait_cnt_d;
  logic [15:0]            timeout_cnt_q,  timeout_cnt_d;
  logic [15:0]            overrun_cnt_q,  overrun_cnt_d;
  logic                   overrun_flag_q, overrun_flag_d;
  logic [FRAME_WIDTH-1:0] tx_frame_q,     tx_frame_d;
  logic                   done_q,         done_d;

  logic    addr_bad;
  status_e resp_status;

  assign addr_bad    = {1'b0, addr_q} >= ADDR_LIM;
  // A pending overrun is reported only in place of an otherwise clean OK.
  assign resp_status = (overrun_flag_q && status_q == ST_OK) ? ST_OVERRUN : status_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q        <= S_IDLE;
      cmd_q          <= CMD_NOP;
      status_q       <= ST_OK;
      addr_q         <= '0;
      data_q         <= '0;
      wait_cnt_q     <= '0;
      timeout_cnt_q  <= '0;
      overrun_cnt_q  <= '0;
      overrun_flag_q <= 1'b0;
      tx_frame_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      status_q       <= status_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
      overrun_cnt_q  <= overrun_cnt_d;
      overrun_flag_q <= overrun_flag_d;
      tx_frame_q     <= tx_frame_d;
      done_q         <= done_d;
    end
  end

  // NOTE: every signal gets a default first, so no path through the case
  // statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    status_d       = status_q;
    addr_d         = addr_q;
    data_d         = data_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    overrun_cnt_d  = overrun_cnt_q;
    overrun_flag_d = overrun_flag_q;
    tx_frame_d     = tx_frame_q;
    done_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iRX_VALID) begin
          cmd_d   = cmd_e'(ivRX_FRAME[FRAME_WIDTH-1 -: 2]);
          addr_d  = ivRX_FRAME[FRAME_WIDTH-3 -: ADDR_WIDTH];
          data_d  = ivRX_FRAME[DATA_WIDTH-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        status_d   = ST_OK;
        wait_cnt_d = '0;
        unique case (cmd_q)
          CMD_NOP: begin
            data_d  = '0;
            state_d = S_RESP;
          end
          CMD_STATUS: begin
            data_d  = DATA_WIDTH'({timeout_cnt_q, overrun_cnt_q});
            state_d = S_RESP;
          end
          default: begin
            if (addr_bad) begin
              status_d = ST_BAD_ADDR;
              data_d   = '0;
              state_d  = S_RESP;
            end else begin
              state_d  = S_BUS;
            end
          end
        endcase
      end
      S_BUS: begin
        // Ack is checked first so an ack on the last allowed cycle still wins.
        if (iBUS_ACK) begin
          if (cmd_q == CMD_READ) data_d = ivBUS_RDATA;
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (wait_cnt_q == CNT_LAST) begin
          status_d      = ST_TIMEOUT;
          data_d        = '0;
          timeout_cnt_d = (timeout_cnt_q == '1) ? timeout_cnt_q : timeout_cnt_q + 16'd1;
          state_d       = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (!iTX_HOLD) begin
          tx_frame_d = {resp_status, addr_q, data_q};
          done_d     = 1'b1;
          state_d    = S_IDLE;
          if (resp_status == ST_OVERRUN) overrun_flag_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after the case so a fresh overrun outranks the clear above.
    if (iRX_VALID && state_q != S_IDLE) begin
      overrun_cnt_d  = (overrun_cnt_q == '1) ? overrun_cnt_q : overrun_cnt_q + 16'd1;
      overrun_flag_d = 1'b1;
    end
  end

  always_comb begin
    oBUS_REQ    = (state_q == S_BUS);
    oBUS_WR     = oBUS_REQ && (cmd_q == CMD_WRITE);
    ovBUS_ADDR  = oBUS_REQ ? addr_q : '0;
    ovBUS_WDATA = oBUS_WR ? data_q : '0;
    ovTX_FRAME  = tx_frame_q;
    oDONE       = done_q;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command sequencer between the SPI slave shift engine and the CPLD local register bus.
- Takes each complete received SPI frame and decodes it as {CMD, ADDR, DATA}.
- Runs one local-bus write or read per frame, with an ack handshake and a timeout.
- Builds a response frame that the SPI slave shifts out on the next SPI transaction.

Parameters:
- ADDR_WIDTH, 12, register address width.
- DATA_WIDTH, 32, register data width.
- FRAME_WIDTH, 2+ADDR_WIDTH+DATA_WIDTH (46), SPI frame width. Derived; do not override.
- ADDR_LIMIT, 'h100, first invalid address. Valid addresses are 0..ADDR_LIMIT-1.
- TIMEOUT, 255, maximum iClk cycles to wait for iBUS_ACK, counted from oBUS_REQ rise.

Ports:
- iClk  in  1  system clock.
- iRstn  in  1  reset, asynchronous, active-low.
- ivRX_FRAME  in  FRAME_WIDTH  received frame: [FW-1:FW-2]=CMD, then ADDR, then DATA in the LSBs.
- iRX_VALID  in  1  one-cycle pulse; ivRX_FRAME is valid in that cycle.
- iTX_HOLD  in  1  high while an SPI transaction is in progress; ovTX_FRAME must not change while it is high.
- ovTX_FRAME  out  FRAME_WIDTH  response frame {STATUS[1:0], ADDR, DATA}.
- oBUS_REQ  out  1  local-bus request.
- oBUS_WR  out  1  1 = write, 0 = read.
- ovBUS_ADDR  out  ADDR_WIDTH  bus address.
- ovBUS_WDATA  out  DATA_WIDTH  bus write data.
- iBUS_ACK  in  1  bus completion. Sampled only while oBUS_REQ is high.
- ivBUS_RDATA  in  DATA_WIDTH  read data, valid in the cycle iBUS_ACK is high.
- oDONE  out  1  one-cycle pulse when ovTX_FRAME is updated.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, internal counters and flags 0.
- CMD encoding: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
- STATUS encoding: 00 OK, 01 TIMEOUT, 10 BAD_ADDR, 11 OVERRUN_SEEN.
- IDLE:
  - iRX_VALID=1: latch CMD/ADDR/DATA, go to DECODE on the next edge.
- DECODE (1 cycle):
  - NOP -> RESP. STATUS=OK, DATA=0.
  - STATUS cmd -> RESP. DATA = {timeout_cnt[15:0], overrun_cnt[15:0]}, zero-extended or truncated to DATA_WIDTH.
  - WRITE/READ with ADDR>=ADDR_LIMIT -> RESP. STATUS=BAD_ADDR, DATA=0. No bus cycle is issued.
  - Otherwise -> BUS. Drive oBUS_REQ=1, oBUS_WR, ovBUS_ADDR, ovBUS_WDATA (ovBUS_WDATA=0 for reads).
- BUS:
  - Request fields are held stable until exit.
  - Wait counter starts at 0 and increments every cycle.
  - iBUS_ACK=1: oBUS_REQ=0 next cycle. On a read, capture ivBUS_RDATA; on a write, DATA=echoed write data. STATUS=OK -> RESP.
  - Counter reaches TIMEOUT with no ack: drop oBUS_REQ, STATUS=TIMEOUT, DATA=0, timeout_cnt+1 (saturating) -> RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Minimum latency: iRX_VALID at T -> oBUS_REQ high at T+2.
- RESP:
  - While iTX_HOLD=1: stay in RESP.
  - When iTX_HOLD=0: load ovTX_FRAME = {STATUS, ADDR, DATA}, pulse oDONE -> IDLE.
  - If the sticky overrun flag is set and STATUS would be OK, send 11 instead, then clear the flag.
- Overrun: iRX_VALID while not in IDLE:
  - The frame is dropped and the current operation is not disturbed.
  - overrun_cnt+1 (saturating at all-ones); sticky overrun flag set.
- ovTX_FRAME holds its value between updates and never changes while iTX_HOLD=1.
- Asserting reset mid-bus-cycle drops oBUS_REQ immediately. No ack is awaited after reset.
- Counters saturate and do not wrap. They clear only on reset.

Test Plan:
1. Write: RX frame CMD=01, ADDR='h010, DATA='hDEADBEEF; ack after 3 cycles.
   -> oBUS_REQ=1, oBUS_WR=1, addr 'h010, wdata 'hDEADBEEF held for 3 cycles.
   -> ovTX_FRAME={00,'h010,'hDEADBEEF}; oDONE pulses once.
2. Read: CMD=10, ADDR='h020; ack with ivBUS_RDATA='h12345678.
   -> oBUS_WR=0, ovBUS_WDATA=0.
   -> ovTX_FRAME={00,'h020,'h12345678}.
3. Bad address: CMD=01, ADDR='h100.
   -> oBUS_REQ never rises.
   -> ovTX_FRAME={10,'h100,0}.
4. Timeout: CMD=10, ADDR='h005, no ack.
   -> oBUS_REQ drops after 255 cycles.
   -> ovTX_FRAME={01,'h005,0}.
   -> A following STATUS cmd returns DATA[31:16]=1.
5. Overrun and hold:
   -> Second iRX_VALID during BUS: dropped, and the next OK response carries STATUS=11.
   -> iTX_HOLD=1 held 10 cycles in RESP: ovTX_FRAME unchanged until iTX_HOLD falls, then updates with one oDONE.
   -> A subsequent STATUS cmd returns DATA[15:0]=1.
6. Reset mid-operation: iRstn low while oBUS_REQ=1.
   -> All outputs 0 immediately.
   -> After release, the block accepts a new WRITE normally.
